// File: rtl/mmm_pkg.sv
// Shared core parameters plus the fetch metadata record carried by the PC generator queue.
package mmm_pkg;
  localparam int XLEN = 32;
  localparam int HLEN = 8;
  localparam logic [XLEN-1:0] BOOT_PC = 32'h0000_0200;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [HLEN-1:0] index;
    logic            taken;
    logic [XLEN-1:0] target;
  } fetch_meta_t;

  localparam logic [1:0] ST_BOOT    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_BLOCKED = 2'd2;

  // Instruction PCs are word aligned; the low two bits are always cleared.
  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bus of pc_gen: resolution, BPU, icache request and metadata queue head.
interface pc_gen_if;
  import mmm_pkg::*;
  logic            flush_i;
  logic            res_valid_i;
  logic            res_mispredict_i;
  logic            res_taken_i;
  logic [XLEN-1:0] res_pc_i;
  logic [XLEN-1:0] res_target_i;
  logic            pred_taken_i;
  logic [XLEN-1:0] pred_target_i;
  logic [HLEN-1:0] pred_index_i;
  logic [XLEN-1:0] pc_o;
  logic            fetch_valid_o;
  logic            fetch_ready_i;
  logic            meta_valid_o;
  logic            meta_ready_i;
  logic [XLEN-1:0] meta_pc_o;
  logic [HLEN-1:0] meta_index_o;
  logic            meta_taken_o;
  logic [XLEN-1:0] meta_target_o;

  modport master (
    input  flush_i, res_valid_i, res_mispredict_i, res_taken_i, res_pc_i, res_target_i,
           pred_taken_i, pred_target_i, pred_index_i, fetch_ready_i, meta_ready_i,
    output pc_o, fetch_valid_o, meta_valid_o, meta_pc_o, meta_index_o, meta_taken_o,
           meta_target_o
  );
  modport slave (
    output flush_i, res_valid_i, res_mispredict_i, res_taken_i, res_pc_i, res_target_i,
           pred_taken_i, pred_target_i, pred_index_i, fetch_ready_i, meta_ready_i,
    input  pc_o, fetch_valid_o, meta_valid_o, meta_pc_o, meta_index_o, meta_taken_o,
           meta_target_o
  );
endinterface

// File: rtl/pc_gen_fifo.sv
// In-flight fetch metadata queue; head is presented combinationally, zero when empty.
module pc_gen_fifo
  import mmm_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fetch_meta_t din,
  output fetch_meta_t head,
  output logic        full,
  output logic        empty
);
  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  fetch_meta_t       mem [QDEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign full  = (cnt == (AW+1)'(QDEPTH));
  assign empty = (cnt == '0);
  assign head  = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with BPU-following and mispredict redirect.
// Define PC_GEN_PRED_EN to follow BPU predictions; otherwise fetch is strictly sequential.
module pc_gen
  import mmm_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  pc_gen_if.master bus
);
  logic [1:0]      state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            fetch_valid, accept, redirect, clear, push, pop, full, empty;
  logic            taken_eff;
  fetch_meta_t     din, head;

  // Full queue in RUN must not request; the FSM parks in BLOCKED next cycle.
  assign fetch_valid = (state == ST_RUN) && !full;
  assign accept      = fetch_valid && bus.fetch_ready_i;
  assign redirect    = bus.res_valid_i && bus.res_mispredict_i;
  assign clear       = redirect || bus.flush_i;
  assign push        = accept && !clear;
  assign pop         = !empty && bus.meta_ready_i;

`ifdef PC_GEN_PRED_EN
  assign taken_eff = bus.pred_taken_i;
  assign din       = '{pc: pc, index: bus.pred_index_i, taken: bus.pred_taken_i,
                       target: bus.pred_target_i};
`else
  assign taken_eff = 1'b0;
  assign din       = '{pc: pc, index: '0, taken: 1'b0, target: '0};
`endif

  always_comb begin
    pc_nxt = pc;
    if (redirect)
      pc_nxt = align4(bus.res_taken_i ? bus.res_target_i : bus.res_pc_i + XLEN'(4));
    else if (accept)
      pc_nxt = align4(taken_eff ? bus.pred_target_i : pc + XLEN'(4));
  end

  // A flush or redirect empties the queue, so BLOCKED must release on it too.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT:    state_nxt = ST_RUN;
      ST_RUN:     if (full && !pop && !clear) state_nxt = ST_BLOCKED;
      ST_BLOCKED: if (pop || clear) state_nxt = ST_RUN;
      default:    state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_BOOT;
      pc    <= BOOT_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  pc_gen_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (push),
    .pop     (pop),
    .flush   (clear),
    .din     (din),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  assign bus.pc_o          = pc;
  assign bus.fetch_valid_o = fetch_valid;
  assign bus.meta_valid_o  = !empty;
  assign bus.meta_pc_o     = head.pc;
  assign bus.meta_index_o  = head.index;
  assign bus.meta_taken_o  = head.taken;
  assign bus.meta_target_o = head.target;
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
- REQ-001 SHALL have parameter QDEPTH, default 2, meaning in-flight fetch metadata queue depth (power of two, >=2).
- REQ-002 SHALL have ports, clock and reset first:
  - clk_i  in  1  single clock, all state on rising edge.
  - rst_n_i  in  1  reset, asynchronous, active-low.
  - flush_i  in  1  pipeline flush: drops the queue, PC unchanged.
  - res_valid_i  in  1  branch resolution valid.
  - res_mispredict_i  in  1  resolved branch was mispredicted.
  - res_taken_i  in  1  resolved direction.
  - res_pc_i  in  XLEN  resolved branch PC.
  - res_target_i  in  XLEN  resolved target.
  - pred_taken_i  in  1  BPU prediction for current pc_o.
  - pred_target_i  in  XLEN  BPU predicted target.
  - pred_index_i  in  HLEN  BPU history index.
  - pc_o  out  XLEN  fetch PC, also drives the BPU PC input.
  - fetch_valid_o  out  1  fetch request valid.
  - fetch_ready_i  in  1  icache accepts the request.
  - meta_valid_o  out  1  queue head valid.
  - meta_ready_i  in  1  downstream pops the head.
  - meta_pc_o  out  XLEN  head PC.
  - meta_index_o  out  HLEN  head history index.
  - meta_taken_o  out  1  head predicted direction.
  - meta_target_o  out  XLEN  head predicted target.

Function
- REQ-003 SHALL run FSM states BOOT, RUN, BLOCKED.
  - BOOT: entered on reset, lasts exactly 1 cycle, fetch_valid_o=0, then RUN.
  - RUN -> BLOCKED when the queue is full with no pop this cycle; BLOCKED -> RUN when an entry is popped.
- REQ-004 SHALL assert fetch_valid_o only in RUN.
- REQ-005 SHALL treat a fetch as accepted when fetch_valid_o && fetch_ready_i. On accept:
  - push {pc_o, pred_index_i, pred_taken_i, pred_target_i}.
  - next pc_o = pred_taken_i ? pred_target_i : pc_o+4.
- REQ-006 SHALL hold pc_o and fetch_valid_o stable while valid and not ready, except on redirect.
- REQ-007 SHALL redirect on res_valid_i && res_mispredict_i, taking priority over everything else:
  - next pc_o = res_taken_i ? res_target_i : res_pc_i+4.
  - queue emptied; any same-cycle accept discarded and not pushed.
- REQ-008 SHALL, on flush_i without a redirect, empty the queue and suppress that cycle's push; pc_o still advances if accepted.
- REQ-009 SHALL force bits [1:0] of every computed next PC to 0; PC+4 wraps modulo 2^XLEN.
- REQ-010 SHALL, on a simultaneous push and pop in the same cycle, keep occupancy unchanged; a push when full SHALL never occur.
- REQ-011 SHALL add no latency: meta outputs come directly from the queue head, and meta_valid_o=0 when empty.
- REQ-012 SHALL make a correctly predicted resolution (res_mispredict_i=0) have no effect.

Reset
- REQ-013 SHALL, on reset, set: pc_o=BOOT_PC, FSM=BOOT, queue empty, fetch_valid_o=0, meta_valid_o=0, all meta data outputs 0.
- REQ-014 SHALL abort any pending request on reset assertion mid-operation, with no entry retained.

Configuration
- REQ-015 SHALL, with PC_GEN_PRED_EN defined, follow predictions per REQ-005.
- REQ-016 SHALL, without PC_GEN_PRED_EN, always use next pc_o = pc_o+4 and push meta_taken=0, meta_target=0, meta_index=0.

Structure
- REQ-017 SHALL take XLEN, HLEN and BOOT_PC from mmm_pkg, with fetch_meta_t (pc, index, taken, target) added there.
- REQ-018 SHALL implement the queue as sub-module pc_gen_fifo (QDEPTH, fetch_meta_t payload, push/pop/flush/full/empty).

Verification
- REQ-019 Reset release with BOOT_PC=0x200 and ready=1 -> first accept at pc 0x200, then 0x204, 0x208, with fetch_valid_o low during the BOOT cycle.
- REQ-020 pred_taken_i=1, target 0x400 at pc 0x208 -> next pc_o=0x400; queue entry {0x208,idx,1,0x400}.
- REQ-021 fetch_ready_i=0 for 3 cycles -> pc_o and fetch_valid_o stable; meta_ready_i=0 with 2 accepts -> BLOCKED, fetch_valid_o=0 until a pop.
- REQ-022 Mispredict res_pc=0x300, taken=0, in the same cycle as an accept -> queue empty, next pc_o=0x304, accepted request not pushed.
- REQ-023 pc_o=0xFFFFFFFC accepted, not taken -> next pc_o=0x0; target 0x403 -> pc_o=0x400; without PC_GEN_PRED_EN, taken predictions ignored.
